multicycle_ctrl: RTL and testbench

Multicycle control unit for the 64-bit LEGv8 datapath. It sequences a single shared ALU, instruction register, register file and data memory through fetch, decode, execute, memory and writeback cycles, replacing the single-cycle combinational control. It waits on a ready handshake from data memory, halts permanently on an unsupported opcode, and keeps cycle and retired-instruction counters for the bench.

---
 rtl/multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle LEGv8 control FSM with memory handshake and perf counters
// Sequences the shared ALU/IR/regfile/memory datapath; halts permanently on unsupported opcodes.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic [3:0]       State,
  output logic             Halted,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_R_WB   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_LD_WB  = 4'd6,
    S_MEM_WR = 4'd7,
    S_BR_CB  = 4'd8,
    S_BR_B   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  state_t            state_q, state_d;
  logic              reg2loc_q, reg2loc_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic              retire;

  logic is_rtype, is_ldur, is_stur, is_cbz, is_b;

  always_comb begin
    is_rtype = (Opcode == 11'h458) || (Opcode == 11'h658) ||
               (Opcode == 11'h450) || (Opcode == 11'h550);
    is_ldur  = (Opcode == 11'h7C2);
    is_stur  = (Opcode == 11'h7C0);
    is_cbz   = (Opcode[10:3] == 8'hB4);
    is_b     = (Opcode[10:5] == 6'h05);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      reg2loc_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      reg2loc_q <= reg2loc_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reg2loc_d = reg2loc_q;
    retire    = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    Halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        // Rt-read selection is remembered so later states need not look at Opcode.
        reg2loc_d = is_stur | is_cbz;
        if (is_rtype)               state_d = S_EXEC_R;
        else if (is_ldur | is_stur) state_d = S_ADDR;
        else if (is_cbz)            state_d = S_BR_CB;
        else if (is_b)              state_d = S_BR_B;
        else                        state_d = S_HALT;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = is_ldur ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        if (MemReady) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BR_CB: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 1'b1;
        PCWrite = Zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BR_B: begin
        PCWrite = 1'b1;
        PCSrc   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_comb begin
    cycle_d = (state_q == S_HALT) ? cycle_q : cycle_q + CNT_W'(1);
    instr_d = retire ? instr_q + CNT_W'(1) : instr_q;
    if (state_q == S_DECODE) Reg2Loc = is_stur | is_cbz;
    else                     Reg2Loc = (state_q != S_FETCH) && reg2loc_q;
  end

  assign State      = state_q;
  assign CycleCount = cycle_q;
  assign InstrCount = instr_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
// Reference model: per-instruction state lists derived from the class, plus plain counters.
module tb_multicycle_ctrl;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CB = 3, C_B = 4, C_ILL = 5;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, PCSrc, IRWrite, Reg2Loc, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp;
  logic        MemRead, MemWrite, MemtoReg, Halted;
  logic [3:0]  State;
  logic [31:0] CycleCount, InstrCount;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = '0;
  logic [31:0] ins = '0;
  int          mr_hi = 0;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .Reg2Loc(Reg2Loc),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .State(State),
    .Halted(Halted), .CycleCount(CycleCount), .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  // {PCWrite,PCSrc,IRWrite,Reg2Loc,RegWrite,ALUSrcA,ALUSrcB,ALUOp,MemRead,MemWrite,MemtoReg,Halted}
  function automatic logic [13:0] exp_ctrl(input int st, input logic z, input logic r2l);
    logic pcw, pcs, irw, rw, asa, mrd, mwr, m2r, h;
    logic [1:0] asb, aop;
    {pcw, pcs, irw, rw, asa, mrd, mwr, m2r, h} = '0;
    asb = 2'b00; aop = 2'b00;
    case (st)
      0:  begin pcw = 1; irw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; aop = 2'b10; end
      3:  rw = 1;
      4:  begin asa = 1; asb = 2'b10; end
      5:  mrd = 1;
      6:  begin rw = 1; m2r = 1; end
      7:  mwr = 1;
      8:  begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; end
      9:  begin pcw = 1; pcs = 1; end
      10: h = 1;
      default: ;
    endcase
    return {pcw, pcs, irw, (st != 0) && r2l, rw, asa, asb, aop, mrd, mwr, m2r, h};
  endfunction

  function automatic logic [13:0] act_ctrl();
    return {PCWrite, PCSrc, IRWrite, Reg2Loc, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
            MemRead, MemWrite, MemtoReg, Halted};
  endfunction

  function automatic logic [10:0] op_for(input int cls);
    logic [10:0] r_ops [4];
    r_ops[0] = 11'h458; r_ops[1] = 11'h658; r_ops[2] = 11'h450; r_ops[3] = 11'h550;
    case (cls)
      C_R:  return r_ops[$urandom_range(0, 3)];
      C_LD: return 11'h7C2;
      C_ST: return 11'h7C0;
      C_CB: return {8'hB4, 3'($urandom)};
      C_B:  return {6'h05, 5'($urandom)};
      default: return 11'h000;
    endcase
  endfunction

  task automatic step(input int st, input int cls, input logic [10:0] op,
                      input logic z, input logic mr, input bit ret);
    logic [13:0] e;
    Opcode = op; Zero = z; MemReady = mr;
    #1;
    e = exp_ctrl(st, z, (cls == C_ST) || (cls == C_CB));
    checks++;
    if (State !== 4'(st)) begin
      errors++; $display("FAIL state: got %0d expected %0d", State, st);
    end
    checks++;
    if (act_ctrl() !== e) begin
      errors++; $display("FAIL ctrl st%0d: got %b expected %b", st, act_ctrl(), e);
    end
    checks++;
    if (CycleCount !== cyc) begin
      errors++; $display("FAIL cyclecount: got %0d expected %0d", CycleCount, cyc);
    end
    checks++;
    if (InstrCount !== ins) begin
      errors++; $display("FAIL instrcount: got %0d expected %0d", InstrCount, ins);
    end
    if (MemRead === 1'b1) mr_hi++;
    @(posedge CLK); #1;
    cyc++;
    if (ret) ins++;
  endtask

  // zf < 0 means Zero is randomized every cycle
  task automatic run_instr(input logic [10:0] op, input int cls, input int waits, input int zf);
    int q[$];
    int wc;
    logic [10:0] o;
    logic z, mr;
    q = '{0, 1};
    case (cls)
      C_R:  q = '{0, 1, 2, 3};
      C_LD: begin q = '{0, 1, 4}; repeat (waits + 1) q.push_back(5); q.push_back(6); end
      C_ST: begin q = '{0, 1, 4}; repeat (waits + 1) q.push_back(7); end
      C_CB: q = '{0, 1, 8};
      C_B:  q = '{0, 1, 9};
      default: ;
    endcase
    wc = 0;
    foreach (q[i]) begin
      o  = (q[i] == 0 || q[i] == 1 || q[i] == 4) ? op : 11'($urandom);
      z  = (zf < 0) ? 1'($urandom) : zf[0];
      mr = 1'($urandom);
      if (q[i] == 5 || q[i] == 7) begin
        mr = (wc < waits) ? 1'b0 : 1'b1;
        wc++;
      end
      step(q[i], cls, o, z, mr, (cls != C_ILL) && (i == q.size() - 1));
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    MemReady = 1'($urandom);
    #1;
    checks++;
    if (State !== 4'd0 || Halted !== 1'b0 || CycleCount !== 32'd0 || InstrCount !== 32'd0) begin
      errors++;
      $display("FAIL reset: got st=%0d h=%b cyc=%0d ins=%0d expected 0/0/0/0",
               State, Halted, CycleCount, InstrCount);
    end
    checks++;
    if (act_ctrl() !== exp_ctrl(0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset ctrl: got %b expected %b", act_ctrl(), exp_ctrl(0, 1'b0, 1'b0));
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    cyc = '0; ins = '0;
  endtask

  task automatic test_rtype();
    logic [10:0] ops [4];
    ops[0] = 11'h458; ops[1] = 11'h658; ops[2] = 11'h450; ops[3] = 11'h550;
    test_reset();
    for (int i = 0; i < 4; i++) run_instr(ops[i], C_R, 0, -1);
    checks++;
    if (InstrCount !== 32'd4 || CycleCount !== 32'd16) begin
      errors++; $display("FAIL rtype totals: got ins=%0d cyc=%0d expected 4/16", InstrCount, CycleCount);
    end
  endtask

  task automatic test_ldur_wait();
    logic [31:0] c0;
    c0 = CycleCount;
    mr_hi = 0;
    run_instr(11'h7C2, C_LD, 3, -1);
    checks++;
    if (mr_hi != 4) begin
      errors++; $display("FAIL ldur memread cycles: got %0d expected 4", mr_hi);
    end
    checks++;
    if (CycleCount - c0 !== 32'd8) begin
      errors++; $display("FAIL ldur latency: got %0d expected 8", CycleCount - c0);
    end
  endtask

  task automatic test_cbz();
    logic [31:0] c0, i0;
    for (int t = 0; t < 2; t++) begin
      c0 = CycleCount; i0 = InstrCount;
      run_instr(op_for(C_CB), C_CB, 0, 1 - t);
      checks++;
      if (CycleCount - c0 !== 32'd3 || InstrCount - i0 !== 32'd1) begin
        errors++;
        $display("FAIL cbz z=%0d: got cyc=%0d ins=%0d expected 3/1", 1 - t, CycleCount - c0, InstrCount - i0);
      end
    end
  endtask

  task automatic test_b_stur();
    logic [31:0] c0;
    run_instr(op_for(C_B), C_B, 0, -1);
    c0 = CycleCount;
    run_instr(11'h7C0, C_ST, 2, -1);
    checks++;
    if (CycleCount - c0 !== 32'd6) begin
      errors++; $display("FAIL stur latency: got %0d expected 6", CycleCount - c0);
    end
  endtask

  task automatic test_back_to_back();
    int cls;
    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 4);
      run_instr(op_for(cls), cls, $urandom_range(0, 3), -1);
    end
  endtask

  task automatic test_halt();
    run_instr(11'h000, C_ILL, 0, -1);
    for (int n = 0; n < 10; n++) begin
      Opcode = 11'($urandom); Zero = 1'($urandom); MemReady = 1'($urandom);
      #1;
      checks++;
      if (State !== 4'd10 || act_ctrl() !== exp_ctrl(10, 1'b0, 1'b0)) begin
        errors++; $display("FAIL halt hold: got st=%0d ctrl=%b expected 10/%b", State, act_ctrl(), exp_ctrl(10, 1'b0, 1'b0));
      end
      checks++;
      if (CycleCount !== cyc || InstrCount !== ins) begin
        errors++; $display("FAIL halt freeze: got cyc=%0d ins=%0d expected %0d/%0d", CycleCount, InstrCount, cyc, ins);
      end
      @(posedge CLK); #1;
    end
    test_reset();
    run_instr(op_for(C_R), C_R, 0, -1);
  endtask

  task automatic test_mid_wait_reset();
    logic [10:0] o;
    o = 11'h7C0;
    step(0, C_ST, o, 1'b0, 1'b1, 1'b0);
    step(1, C_ST, o, 1'b0, 1'b1, 1'b0);
    step(4, C_ST, o, 1'b0, 1'b1, 1'b0);
    step(7, C_ST, 11'($urandom), 1'b0, 1'b0, 1'b0);
    MemReady = 1'b0;
    #1;
    checks++;
    if (State !== 4'd7 || MemWrite !== 1'b1) begin
      errors++; $display("FAIL midwait pre: got st=%0d mw=%b expected 7/1", State, MemWrite);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0 || MemWrite !== 1'b0 || CycleCount !== 32'd0 || InstrCount !== 32'd0) begin
      errors++;
      $display("FAIL midwait reset: got st=%0d mw=%b cyc=%0d ins=%0d expected 0/0/0/0",
               State, MemWrite, CycleCount, InstrCount);
    end
    checks++;
    if (act_ctrl() !== exp_ctrl(0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL midwait ctrl: got %b expected %b", act_ctrl(), exp_ctrl(0, 1'b0, 1'b0));
    end
    #1;
    Reset = 1'b0;
    cyc = '0; ins = '0;
    run_instr(11'h7C2, C_LD, 1, -1);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_ldur_wait();
    test_cbz();
    test_b_stur();
    test_back_to_back();
    test_halt();
    test_mid_wait_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
